bit_entry_fifo: RTL and testbench
=================================

BIT_ENTRY_FIFO -- requirements
Module: bit_entry_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning bits per entered value; legal range 2..32.
REQ-002 SHALL have parameter DEPTH, default 4, meaning output FIFO entries; power of two, 2..16.
REQ-003 SHALL have parameter MSB_FIRST, default 1, meaning 1 = shift left (first bit lands in the MSB), 0 = shift right (first bit lands in the LSB).
REQ-004 clk  input  1  sole clock; all logic samples on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  entry permitted when high.
REQ-007 btn_zero  input  1  level; a rising edge appends bit 0.
REQ-008 btn_one  input  1  level; a rising edge appends bit 1.
REQ-009 btn_del  input  1  level; a rising edge removes the last appended bit.
REQ-010 btn_next  input  1  level; a rising edge commits a complete entry to the FIFO.
REQ-011 out_ready  input  1  consumer accepts the FIFO head.
REQ-012 out_data  output  WIDTH  FIFO head value.
REQ-013 out_valid  output  1  FIFO non-empty.
REQ-014 entry_value  output  WIDTH  live shift register being composed.
REQ-015 bit_cnt  output  clog2(WIDTH+1)  bits currently entered.
REQ-016 fifo_count  output  clog2(DEPTH+1)  occupied FIFO entries.
REQ-017 overflow  output  1  sticky; a commit was rejected because the FIFO was full.

Function
REQ-018 Edge detection: each button SHALL be registered once; rise = btn & ~btn_d; each edge acts exactly once; no debouncing.
REQ-019 States: EMPTY (bit_cnt=0), PARTIAL (0<bit_cnt<WIDTH), COMPLETE (bit_cnt=WIDTH); state SHALL be derived from bit_cnt.
REQ-020 Append: on a zero/one rise in EMPTY or PARTIAL, the bit SHALL enter per MSB_FIRST, bit_cnt+1, and entry_value SHALL update on the next edge.
REQ-021 Append in COMPLETE SHALL be ignored, with no change to entry_value or bit_cnt.
REQ-022 A zero rise and a one rise in the same cycle SHALL both be ignored.
REQ-023 Delete: in PARTIAL or COMPLETE, the register SHALL shift back with 0 fill and bit_cnt-1; delete in EMPTY is a no-op.
REQ-024 When del and zero/one rise in the same cycle, del SHALL win and the append SHALL be dropped.
REQ-025 Commit: a next rise in COMPLETE with fifo_count<DEPTH SHALL push entry_value and clear entry_value and bit_cnt to 0; the data becomes visible on out_data one cycle later.
REQ-026 A next rise in EMPTY or PARTIAL SHALL be ignored.
REQ-027 A next rise in COMPLETE with the FIFO full and no same-cycle pop SHALL set overflow and retain the entry, so the user can retry.
REQ-028 Pop: out_valid & out_ready SHALL advance the read pointer.
REQ-029 A same-cycle push and pop SHALL both succeed, including when the FIFO is full; fifo_count is unchanged in that case.
REQ-030 Pointers SHALL wrap modulo DEPTH; fifo_count SHALL never exceed DEPTH or underflow.
REQ-031 out_data SHALL be held stable while out_valid=1 and out_ready=0.
REQ-032 enable=0 SHALL clear entry_value and bit_cnt and ignore all buttons; the FIFO, pop handshake and overflow remain active.
REQ-033 overflow SHALL clear only on reset or on an enable 1->0 transition.
REQ-034 Edge registers SHALL keep sampling while enable=0, so a button already held when enable rises produces no edge.

Reset
REQ-035 rst_n=0 SHALL asynchronously force entry_value=0, bit_cnt=0, fifo_count=0, out_valid=0, overflow=0, both pointers=0 and all edge registers=0.
REQ-036 out_data SHALL be 0 during reset; FIFO storage SHALL NOT be required to reset.
REQ-037 Reset asserted mid-entry or mid-handshake SHALL discard all state; release SHALL be synchronous-safe, with no action on the first edge after release.

Verification
REQ-038 WIDTH=8, MSB_FIRST=1: press 1,0,1,1,0,0,1,0 then next -> out_valid=1 and out_data=8'hB2 one cycle after the commit; entry_value=0 and bit_cnt=0.
REQ-039 MSB_FIRST=0: press 1 then seven 0s, then next -> out_data=8'h01.
REQ-040 Press 1,1,1, del, 0 -> bit_cnt=3 and entry_value=8'h06; del in EMPTY -> no change.
REQ-041 DEPTH=4, out_ready=0: commit 5 entries -> fifo_count=4, overflow=1, 5th entry retained with bit_cnt=8; assert out_ready for one cycle and press next -> push accepted, fifo_count=4.
REQ-042 Zero and one rise in the same cycle -> bit_cnt unchanged; a held button produces exactly one append.
REQ-043 Assert rst_n=0 with bit_cnt=5 and fifo_count=2 -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bit_entry_fifo.sv
// Button-driven bit entry: compose WIDTH-bit values one bit at a time,
// then commit each complete value into a small ready/valid output FIFO.
module bit_entry_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         btn_zero,
    input  logic                         btn_one,
    input  logic                         btn_del,
    input  logic                         btn_next,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             entry_value,
    output logic [$clog2(WIDTH+1)-1:0]   bit_cnt,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int FW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(WIDTH);
    localparam logic [FW-1:0] FIFO_FULL = FW'(DEPTH);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_PARTIAL,
        S_COMPLETE
    } state_t;

    state_t           state;
    logic [3:0]       btn_now;
    logic [3:0]       btn_d;
    logic [3:0]       rise;
    logic             armed;
    logic             enable_d;
    logic             append_req;
    logic             append_bit;
    logic [WIDTH-1:0] app_value;
    logic [WIDTH-1:0] del_value;
    logic [WIDTH-1:0] entry_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic             push;
    logic             pop;
    logic             reject;
    logic             fifo_full;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign btn_now = {btn_next, btn_del, btn_one, btn_zero};

    // armed stays low for the first edge after reset so a button held
    // through reset release cannot act.
    assign rise       = btn_now & ~btn_d & {4{armed & enable}};
    assign append_req = rise[0] ^ rise[1];
    assign append_bit = rise[1];

    assign out_valid = (fifo_count != '0);
    assign fifo_full = (fifo_count == FIFO_FULL);
    assign pop       = out_valid & out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign app_value = {entry_value[WIDTH-2:0], append_bit};
            assign del_value = {1'b0, entry_value[WIDTH-1:1]};
        end else begin : g_lsb
            assign app_value = {append_bit, entry_value[WIDTH-1:1]};
            assign del_value = {entry_value[WIDTH-2:0], 1'b0};
        end
    endgenerate

    always_comb begin
        state = S_PARTIAL;
        unique case (1'b1)
            (bit_cnt == '0):       state = S_EMPTY;
            (bit_cnt == CNT_FULL): state = S_COMPLETE;
            default:               state = S_PARTIAL;
        endcase
    end

    always_comb begin
        entry_nxt = entry_value;
        cnt_nxt   = bit_cnt;
        push      = 1'b0;
        reject    = 1'b0;
        if (!enable) begin
            entry_nxt = '0;
            cnt_nxt   = '0;
        end else if (rise[2]) begin
            if (state != S_EMPTY) begin
                entry_nxt = del_value;
                cnt_nxt   = bit_cnt - CW'(1);
            end
        end else if (rise[3] && state == S_COMPLETE) begin
            // A same-cycle pop frees a slot even when full.
            if (!fifo_full || pop) begin
                push      = 1'b1;
                entry_nxt = '0;
                cnt_nxt   = '0;
            end else begin
                reject = 1'b1;
            end
        end else if (append_req && state != S_COMPLETE) begin
            entry_nxt = app_value;
            cnt_nxt   = bit_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_d       <= '0;
            armed       <= 1'b0;
            enable_d    <= 1'b0;
            entry_value <= '0;
            bit_cnt     <= '0;
        end else begin
            btn_d       <= btn_now;
            armed       <= 1'b1;
            enable_d    <= enable;
            entry_value <= entry_nxt;
            bit_cnt     <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + FW'(1);
                2'b01:   fifo_count <= fifo_count - FW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (enable_d && !enable) begin
            overflow <= 1'b0;
        end else if (reject) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= entry_value;
    end

endmodule

// File: tb/tb_bit_entry_fifo.sv
// Scoreboard bench for bit_entry_fifo: MSB-first and LSB-first instances
// share stimulus; committed values are queued and checked on pop.
module tb_bit_entry_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       btn_zero;
    logic       btn_one;
    logic       btn_del;
    logic       btn_next;
    logic       out_ready;

    logic [7:0] o_data, o_entry, l_data, l_entry;
    logic       o_valid, o_ovf, l_valid, l_ovf;
    logic [3:0] o_cnt, l_cnt;
    logic [2:0] o_fcnt, l_fcnt;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] lsb_q[$];
    logic [7:0] m_msb, m_lsb;
    int         m_cnt;
    logic       m_ovf;

    always #5 clk = ~clk;

    bit_entry_fifo #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .btn_zero(btn_zero), .btn_one(btn_one),
        .btn_del(btn_del), .btn_next(btn_next),
        .out_ready(out_ready), .out_data(o_data), .out_valid(o_valid),
        .entry_value(o_entry), .bit_cnt(o_cnt),
        .fifo_count(o_fcnt), .overflow(o_ovf)
    );

    bit_entry_fifo #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .btn_zero(btn_zero), .btn_one(btn_one),
        .btn_del(btn_del), .btn_next(btn_next),
        .out_ready(out_ready), .out_data(l_data), .out_valid(l_valid),
        .entry_value(l_entry), .bit_cnt(l_cnt),
        .fifo_count(l_fcnt), .overflow(l_ovf)
    );

    // k: 0=zero 1=one 2=del 3=next 4=zero+one together
    task automatic press(input int k);
        logic b;
        b = (k == 1);
        @(negedge clk);
        btn_zero = (k == 0) || (k == 4);
        btn_one  = (k == 1) || (k == 4);
        btn_del  = (k == 2);
        btn_next = (k == 3);
        if (k == 0 || k == 1) begin
            if (m_cnt < 8) begin
                m_msb = {m_msb[6:0], b};
                m_lsb = {b, m_lsb[7:1]};
                m_cnt++;
            end
        end else if (k == 2) begin
            if (m_cnt > 0) begin
                m_msb = m_msb >> 1;
                m_lsb = m_lsb << 1;
                m_cnt--;
            end
        end else if (k == 3) begin
            if (m_cnt == 8) begin
                if (exp_q.size() < 4) begin
                    exp_q.push_back(m_msb);
                    lsb_q.push_back(m_lsb);
                    m_msb = '0;
                    m_lsb = '0;
                    m_cnt = 0;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        @(negedge clk);
        btn_zero = 1'b0;
        btn_one  = 1'b0;
        btn_del  = 1'b0;
        btn_next = 1'b0;
    endtask

    task automatic enter_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) press(v[i] ? 1 : 0);
    endtask

    task automatic toggle_enable();
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        m_msb = '0;
        m_lsb = '0;
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b1;
        out_ready = 1'b0;
        btn_zero = 1'b0;
        btn_one = 1'b0;
        btn_del = 1'b0;
        btn_next = 1'b0;
        m_msb = '0;
        m_lsb = '0;
        m_cnt = 0;
        m_ovf = 1'b0;
        #12;
        checks++;
        if ({o_entry, o_cnt, o_fcnt, o_valid, o_ovf, o_data} !== '0) begin
            failures++;
            $display("FAIL reset_state got entry=%h cnt=%0d fcnt=%0d v=%b ovf=%b data=%h want all 0",
                     o_entry, o_cnt, o_fcnt, o_valid, o_ovf, o_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_msb_entry();
        enter_byte(8'hB2);
        checks++;
        if (o_entry !== 8'hB2 || o_cnt !== 4'd8) begin
            failures++;
            $display("FAIL msb_compose got %h/%0d want b2/8", o_entry, o_cnt);
        end
        press(3);
        checks++;
        if (o_valid !== 1'b1 || o_data !== 8'hB2) begin
            failures++;
            $display("FAIL msb_commit got v=%b d=%h want v=1 d=b2", o_valid, o_data);
        end
        checks++;
        if (o_entry !== 8'h00 || o_cnt !== 4'd0 || o_fcnt !== 3'd1) begin
            failures++;
            $display("FAIL msb_clear got e=%h c=%0d f=%0d want 0/0/1", o_entry, o_cnt, o_fcnt);
        end
        @(negedge clk);
        out_ready = 1'b1;
        while (exp_q.size() > 0) begin
            checks++;
            if (o_valid !== 1'b1 || o_data !== exp_q[0] || l_data !== lsb_q[0]) begin
                failures++;
                $display("FAIL msb_drain got v=%b %h/%h want %h/%h",
                         o_valid, o_data, l_data, exp_q[0], lsb_q[0]);
            end
            void'(exp_q.pop_front());
            void'(lsb_q.pop_front());
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_lsb_entry();
        enter_byte(8'h80);
        press(3);
        checks++;
        if (l_valid !== 1'b1 || l_data !== 8'h01) begin
            failures++;
            $display("FAIL lsb_commit got v=%b d=%h want v=1 d=01", l_valid, l_data);
        end
        @(negedge clk);
        out_ready = 1'b1;
        while (exp_q.size() > 0) begin
            checks++;
            if (o_data !== exp_q[0] || l_data !== lsb_q[0]) begin
                failures++;
                $display("FAIL lsb_drain got %h/%h want %h/%h",
                         o_data, l_data, exp_q[0], lsb_q[0]);
            end
            void'(exp_q.pop_front());
            void'(lsb_q.pop_front());
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_delete();
        press(2);
        checks++;
        if (o_cnt !== 4'd0 || o_entry !== 8'h00) begin
            failures++;
            $display("FAIL del_empty got %h/%0d want 00/0", o_entry, o_cnt);
        end
        press(1);
        press(1);
        press(1);
        press(2);
        press(0);
        checks++;
        if (o_cnt !== 4'd3 || o_entry !== 8'h06) begin
            failures++;
            $display("FAIL del_msb got %h/%0d want 06/3", o_entry, o_cnt);
        end
        checks++;
        if (l_entry !== m_lsb || l_cnt !== 4'(m_cnt)) begin
            failures++;
            $display("FAIL del_lsb got %h/%0d want %h/%0d", l_entry, l_cnt, m_lsb, m_cnt);
        end
        @(negedge clk);
        btn_del = 1'b1;
        btn_one = 1'b1;
        @(negedge clk);
        btn_del = 1'b0;
        btn_one = 1'b0;
        checks++;
        if (o_cnt !== 4'd2 || o_entry !== 8'h03) begin
            failures++;
            $display("FAIL del_wins got %h/%0d want 03/2", o_entry, o_cnt);
        end
        toggle_enable();
        checks++;
        if (o_cnt !== 4'd0 || o_entry !== 8'h00) begin
            failures++;
            $display("FAIL disable_clear got %h/%0d want 00/0", o_entry, o_cnt);
        end
    endtask

    task automatic test_simultaneous();
        press(1);
        press(4);
        checks++;
        if (o_cnt !== 4'd1 || o_entry !== 8'h01) begin
            failures++;
            $display("FAIL both_rise got %h/%0d want 01/1", o_entry, o_cnt);
        end
        @(negedge clk);
        btn_zero = 1'b1;
        repeat (5) @(negedge clk);
        btn_zero = 1'b0;
        @(negedge clk);
        checks++;
        if (o_cnt !== 4'd2 || o_entry !== 8'h02) begin
            failures++;
            $display("FAIL held_button got %h/%0d want 02/2", o_entry, o_cnt);
        end
        toggle_enable();
    endtask

    task automatic test_overflow();
        logic [7:0] v;
        for (int n = 0; n < 5; n++) begin
            v = 8'($urandom_range(0, 255));
            enter_byte(v);
            press(3);
        end
        checks++;
        if (o_fcnt !== 3'd4 || o_ovf !== 1'b1 || m_ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_full got f=%0d ovf=%b want 4/1", o_fcnt, o_ovf);
        end
        checks++;
        if (o_cnt !== 4'd8 || o_entry !== m_msb) begin
            failures++;
            $display("FAIL ovf_retain got %h/%0d want %h/8", o_entry, o_cnt, m_msb);
        end
        @(negedge clk);
        out_ready = 1'b1;
        btn_next = 1'b1;
        checks++;
        if (o_data !== exp_q[0] || l_data !== lsb_q[0]) begin
            failures++;
            $display("FAIL ovf_pop got %h/%h want %h/%h", o_data, l_data, exp_q[0], lsb_q[0]);
        end
        void'(exp_q.pop_front());
        void'(lsb_q.pop_front());
        exp_q.push_back(m_msb);
        lsb_q.push_back(m_lsb);
        m_msb = '0;
        m_lsb = '0;
        m_cnt = 0;
        @(negedge clk);
        out_ready = 1'b0;
        btn_next = 1'b0;
        checks++;
        if (o_fcnt !== 3'd4 || o_cnt !== 4'd0 || o_ovf !== 1'b1) begin
            failures++;
            $display("FAIL push_pop_full got f=%0d c=%0d ovf=%b want 4/0/1", o_fcnt, o_cnt, o_ovf);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (o_data !== exp_q[0]) begin
            failures++;
            $display("FAIL hold_stable got %h want %h", o_data, exp_q[0]);
        end
        out_ready = 1'b1;
        while (exp_q.size() > 0) begin
            checks++;
            if (o_valid !== 1'b1 || o_data !== exp_q[0] || l_data !== lsb_q[0]) begin
                failures++;
                $display("FAIL ovf_drain got v=%b %h/%h want %h/%h",
                         o_valid, o_data, l_data, exp_q[0], lsb_q[0]);
            end
            void'(exp_q.pop_front());
            void'(lsb_q.pop_front());
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++;
        if (o_fcnt !== 3'd0 || o_valid !== 1'b0 || o_ovf !== 1'b1) begin
            failures++;
            $display("FAIL drained got f=%0d v=%b ovf=%b want 0/0/1", o_fcnt, o_valid, o_ovf);
        end
        toggle_enable();
        checks++;
        if (o_ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear got %b want 0", o_ovf);
        end
    endtask

    task automatic test_enable_held();
        @(negedge clk);
        enable = 1'b0;
        btn_one = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (o_cnt !== 4'd0) begin
            failures++;
            $display("FAIL enable_held got cnt=%0d want 0", o_cnt);
        end
        btn_one = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        enter_byte(8'h3C);
        press(3);
        enter_byte(8'hA5);
        press(3);
        for (int i = 0; i < 5; i++) press(i % 2);
        checks++;
        if (o_fcnt !== 3'd2 || o_cnt !== 4'd5) begin
            failures++;
            $display("FAIL pre_reset got f=%0d c=%0d want 2/5", o_fcnt, o_cnt);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        btn_one = 1'b1;
        #1;
        checks++;
        if ({o_entry, o_cnt, o_fcnt, o_valid, o_ovf, o_data} !== '0) begin
            failures++;
            $display("FAIL async_reset got e=%h c=%0d f=%0d v=%b ovf=%b d=%h want all 0",
                     o_entry, o_cnt, o_fcnt, o_valid, o_ovf, o_data);
        end
        exp_q.delete();
        lsb_q.delete();
        m_msb = '0;
        m_lsb = '0;
        m_cnt = 0;
        m_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (o_cnt !== 4'd0) begin
            failures++;
            $display("FAIL release_held got cnt=%0d want 0", o_cnt);
        end
        btn_one = 1'b0;
        press(1);
        checks++;
        if (o_cnt !== 4'd1 || o_entry !== 8'h01) begin
            failures++;
            $display("FAIL post_reset got %h/%0d want 01/1", o_entry, o_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_msb_entry();
        test_lsb_entry();
        test_delete();
        test_simultaneous();
        test_overflow();
        test_enable_held();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

endmodule
